alu_seq_unit: RTL and testbench

ALU_SEQ_UNIT -- requirements
Module: alu_seq_unit

---
 rtl/alu_seq_unit.sv | 164 ++++++++++++++++
 tb/tb_alu_seq_unit.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_unit.sv
// Multi-cycle ALU behind a valid/ready handshake.
// Shifts step one bit per cycle and multiply is a 32-step shift-add.
module alu_seq_unit (
  input  logic        CLOCK_50,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  ALU_OP,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] alu_result,
  output logic        zero,
  output logic        overflow
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b010,
    OP_SUB = 3'b011,
    OP_SLT = 3'b100,
    OP_SLL = 3'b101,
    OP_SRL = 3'b110,
    OP_MUL = 3'b111
  } op_e;

  state_e      state_q, state_d;
  op_e         op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] acc_q, acc_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] res_q, res_d;
  logic        zero_q, zero_d;
  logic        ovf_q, ovf_d;
  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;

  logic [31:0] sum, diff, fin_res;
  logic        fin_ovf;

  assign sum  = a_q + b_q;
  assign diff = a_q - b_q;

  // Final result selection; shifts and multiply have already iterated into a_q / acc_q.
  always_comb begin
    fin_res = '0;
    fin_ovf = 1'b0;
    case (op_q)
      OP_AND: fin_res = a_q & b_q;
      OP_OR:  fin_res = a_q | b_q;
      OP_ADD: begin
        fin_res = sum;
        fin_ovf = (a_q[31] == b_q[31]) && (sum[31] != a_q[31]);
      end
      OP_SUB: begin
        fin_res = diff;
        fin_ovf = (a_q[31] != b_q[31]) && (diff[31] != a_q[31]);
      end
      OP_SLT: fin_res = {31'b0, $signed(a_q) < $signed(b_q)};
      OP_SLL: fin_res = a_q;
      OP_SRL: fin_res = a_q;
      OP_MUL: fin_res = acc_q;
      default: fin_res = '0;
    endcase
  end

  // NOTE: every _d starts as its _q so no path through this block leaves a value unassigned (no latches).
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          op_d    = op_e'(ALU_OP);
          a_d     = rs;
          b_d     = rt;
          acc_d   = '0;
          state_d = EXEC;
          case (op_e'(ALU_OP))
            OP_SLL, OP_SRL: cnt_d = {1'b0, rt[4:0]};
            OP_MUL:         cnt_d = 6'd32;
            default:        cnt_d = 6'd0;
          endcase
        end
      end
      EXEC: begin
        if (cnt_q == 6'd0) begin
          res_d   = fin_res;
          zero_d  = (fin_res == 32'd0);
          ovf_d   = fin_ovf;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 6'd1;
          case (op_q)
            OP_SLL: a_d = a_q << 1;
            OP_SRL: a_d = a_q >> 1;
            OP_MUL: begin
              if (b_q[0]) acc_d = acc_q + a_q;
              a_d = a_q << 1;
              b_d = b_q >> 1;
            end
            default: a_d = a_q;
          endcase
        end
      end
      DONE: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    req_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == DONE);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      op_q        <= OP_AND;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      res_q       <= '0;
      zero_q      <= 1'b1;
      ovf_q       <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      res_q       <= res_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign alu_result = res_q;
  assign zero       = zero_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_alu_seq_unit.sv
// Self-checking bench for alu_seq_unit: directed corner cases plus random operations
// compared against a plain-arithmetic reference model.
module tb_alu_seq_unit;

  logic        CLOCK_50 = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  ALU_OP;
  logic [31:0] rs;
  logic [31:0] rt;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] alu_result;
  logic        zero;
  logic        overflow;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] last_res;

  alu_seq_unit dut (
    .CLOCK_50  (CLOCK_50),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .ALU_OP    (ALU_OP),
    .rs        (rs),
    .rt        (rt),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .alu_result(alu_result),
    .zero      (zero),
    .overflow  (overflow)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  // Reference model: result, signed overflow and number of EXEC cycles.
  function automatic void ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output logic v, output int lat);
    longint sa, sb, wide;
    logic [63:0] prod;
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    v    = 1'b0;
    lat  = 1;
    wide = 0;
    case (op)
      3'd0: r = a & b;
      3'd1: r = a | b;
      3'd2: begin wide = sa + sb; r = a + b; end
      3'd3: begin wide = sa - sb; r = a - b; end
      3'd4: r = (sa < sb) ? 32'd1 : 32'd0;
      3'd5: begin r = a << b[4:0]; lat = int'(b[4:0]) + 1; end
      3'd6: begin r = a >> b[4:0]; lat = int'(b[4:0]) + 1; end
      default: begin prod = {32'd0, a} * {32'd0, b}; r = prod[31:0]; lat = 33; end
    endcase
    if (op == 3'd2 || op == 3'd3)
      v = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
  endfunction

  // One full transaction: accept, wait for the response, hold it `hold` cycles, then take it.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int hold, input string tag);
    logic [31:0] exp_r;
    logic        exp_v;
    int          exp_lat;
    int          lat;
    ref_model(op, a, b, exp_r, exp_v, exp_lat);
    check({tag, "/ready_before"}, {31'b0, req_ready}, 32'd1);
    ALU_OP    = op;
    rs        = a;
    rt        = b;
    req_valid = 1'b1;
    rsp_ready = 1'b0;
    tick();
    lat = 0;
    while (!rsp_valid && lat < 100) begin
      req_valid = 1'($urandom);
      ALU_OP    = 3'($urandom);
      rs        = $urandom;
      rt        = $urandom;
      tick();
      lat++;
    end
    req_valid = 1'b0;
    check({tag, "/exec_cycles"}, 32'(lat), 32'(exp_lat));
    check({tag, "/result"}, alu_result, exp_r);
    check({tag, "/zero"}, {31'b0, zero}, {31'b0, exp_r == 32'd0});
    check({tag, "/overflow"}, {31'b0, overflow}, {31'b0, exp_v});
    check({tag, "/ready_busy"}, {31'b0, req_ready}, 32'd0);
    last_res = alu_result;
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'($urandom);
      ALU_OP    = 3'($urandom);
      rs        = $urandom;
      rt        = $urandom;
      tick();
      check({tag, "/hold_valid"}, {31'b0, rsp_valid}, 32'd1);
      check({tag, "/hold_result"}, alu_result, exp_r);
      check({tag, "/hold_flags"}, {30'b0, zero, overflow}, {30'b0, exp_r == 32'd0, exp_v});
      check({tag, "/hold_ready"}, {31'b0, req_ready}, 32'd0);
    end
    // A request held across the take edge must not be accepted there.
    req_valid = 1'b1;
    rsp_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    check({tag, "/released"}, {31'b0, rsp_valid}, 32'd0);
    check({tag, "/idle_ready"}, {31'b0, req_ready}, 32'd1);
  endtask

  initial begin
    reset_n   = 1'b0;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    ALU_OP    = '0;
    rs        = '0;
    rt        = '0;
    last_res  = '0;
    tick();
    tick();
    check("reset/req_ready", {31'b0, req_ready}, 32'd1);
    check("reset/rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("reset/result", alu_result, 32'd0);
    check("reset/zero", {31'b0, zero}, 32'd1);
    check("reset/overflow", {31'b0, overflow}, 32'd0);
    reset_n = 1'b1;
    tick();

    // Basic ops on 7 and 5.
    run_op(3'd0, 32'd7, 32'd5, 0, "and_7_5");  check("and_7_5/lit", last_res, 32'd5);
    run_op(3'd1, 32'd7, 32'd5, 0, "or_7_5");   check("or_7_5/lit", last_res, 32'd7);
    run_op(3'd2, 32'd7, 32'd5, 0, "add_7_5");  check("add_7_5/lit", last_res, 32'd12);
    run_op(3'd3, 32'd7, 32'd5, 0, "sub_7_5");  check("sub_7_5/lit", last_res, 32'd2);
    run_op(3'd4, 32'd7, 32'd5, 0, "slt_7_5");  check("slt_7_5/lit", last_res, 32'd0);

    // Shifts, multiply, overflow corners.
    run_op(3'd5, 32'd7, 32'd5, 0, "sll_7_5");          check("sll_7_5/lit", last_res, 32'd224);
    run_op(3'd6, 32'h8000_0000, 32'd31, 0, "srl_31");  check("srl_31/lit", last_res, 32'd1);
    run_op(3'd5, 32'h1234_5678, 32'hFFFF_FFE0, 0, "sll_0");
    check("sll_0/lit", last_res, 32'h1234_5678);
    run_op(3'd7, 32'd7, 32'd5, 0, "mul_7_5");          check("mul_7_5/lit", last_res, 32'd35);
    run_op(3'd7, 32'h0001_0000, 32'h0001_0000, 0, "mul_wrap");
    check("mul_wrap/lit", last_res, 32'd0);
    run_op(3'd2, 32'h7FFF_FFFF, 32'd1, 0, "add_ovf"); check("add_ovf/lit", last_res, 32'h8000_0000);
    run_op(3'd3, 32'h8000_0000, 32'd1, 0, "sub_ovf"); check("sub_ovf/lit", last_res, 32'h7FFF_FFFF);
    run_op(3'd0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 0, "and_no_ovf");
    run_op(3'd4, 32'hFFFF_FFFF, 32'd1, 0, "slt_neg");  check("slt_neg/lit", last_res, 32'd1);

    // Long backpressure with request noise in DONE.
    run_op(3'd2, 32'd100, 32'd23, 10, "backpressure");

    // Reset during MUL EXEC cycle 10, with req_valid and rsp_ready also high.
    ALU_OP    = 3'd7;
    rs        = 32'd7;
    rt        = 32'd5;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    repeat (9) tick();
    check("mul_rst/still_busy", {31'b0, rsp_valid}, 32'd0);
    reset_n   = 1'b0;
    req_valid = 1'b1;
    rsp_ready = 1'b1;
    ALU_OP    = 3'd2;
    tick();
    reset_n   = 1'b1;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    check("mul_rst/rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("mul_rst/req_ready", {31'b0, req_ready}, 32'd1);
    check("mul_rst/result", alu_result, 32'd0);
    check("mul_rst/zero", {31'b0, zero}, 32'd1);
    check("mul_rst/overflow", {31'b0, overflow}, 32'd0);
    repeat (40) tick();
    check("mul_rst/no_response", {31'b0, rsp_valid}, 32'd0);
    run_op(3'd2, 32'd7, 32'd5, 0, "post_rst_add");
    check("post_rst_add/lit", last_res, 32'd12);

    // Random operations.
    for (int n = 0; n < 40; n++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      op = 3'($urandom);
      a  = $urandom;
      b  = $urandom;
      if (($urandom % 4) == 0) b = a;
      if (($urandom % 4) == 0) a = {1'b0, 31'($urandom)};
      run_op(op, a, b, int'($urandom_range(0, 2)), $sformatf("rand%0d_op%0d", n, op));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
